nibble_add_sequencer: RTL and testbench
=======================================

// Module: nibble_add_sequencer
// PURPOSE
//  Sequences an external 4-bit full-adder datapath to add or subtract two WIDTH-bit
//  operands, one nibble per clock, LSB nibble first, with a registered inter-nibble carry.
//  Sits between a requester (start/done handshake) and one shared 4-bit adder instance.
//  Also handles operand latching, per-nibble operand steering, result assembly and status.
// PARAMETERS
//  WIDTH    16  operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4  derived (localparam), number of adder passes
// PORTS
//  clk       in   1      single clock, all state rising-edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; sampled only in IDLE or DONE
//  op        in   1      0 = a+b+c_in, 1 = a-b-c_in (c_in acts as borrow-in)
//  a         in   WIDTH  operand A, latched on accepted start
//  b         in   WIDTH  operand B, latched on accepted start
//  c_in      in   1      carry/borrow in, latched on accepted start
//  busy      out  1      high while state == RUN
//  done      out  1      one-cycle pulse, state == DONE
//  sum       out  WIDTH  result register, held until next accepted start
//  c_out     out  1      final carry (op=1: 1 = no borrow), held like sum
//  add_a     out  4      to adder: current nibble of latched A
//  add_b     out  4      to adder: current nibble of latched B (inverted when op=1)
//  add_cin   out  1      to adder: carry register
//  add_sum   in   4      from adder: nibble sum (combinational return)
//  add_cout  in   1      from adder: nibble carry
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, sum=0, c_out=0, busy=0, done=0,
//   latched a/b/op=0; takes effect immediately, including mid-RUN (operation discarded).
//  States: IDLE -> RUN on start; RUN -> RUN while idx<NIBBLES-1; RUN -> DONE after
//   nibble NIBBLES-1 captured; DONE -> RUN if start, else DONE -> IDLE.
//  Accepted start (edge k): latch a, b, op; carry <= c_in ^ op; idx <= 0; sum and c_out
//   unchanged until written by RUN; state <= RUN.
//  RUN: add_a = a_r[4*idx+:4]; add_b = b_r[4*idx+:4] ^ {4{op_r}}; add_cin = carry.
//   Each edge: sum[4*idx+:4] <= add_sum; carry <= add_cout; idx <= idx+1.
//   On the last nibble, c_out <= add_cout as well.
//  Latency: start at edge k -> RUN edges k+1..k+NIBBLES -> done=1 during the cycle
//   after edge k+NIBBLES (NIBBLES+1 edges after start). Throughput: one op per NIBBLES+1.
//  IDLE/DONE: add_a = add_b = 0, add_cin = 0 (adder inputs quiet).
//  start while RUN: ignored, no effect on latched operands or result.
//  start during DONE cycle: accepted (back-to-back), done still pulses that cycle.
//  Arithmetic: modulo 2^WIDTH; sub result is a + ~b + ~c_in; no overflow flag.
//  idx wraps never: counter width clog2(NIBBLES), cleared on every accepted start.
// TESTING
//  (WIDTH=16; bench drives add_sum/add_cout from a 4-bit full-adder model)
//  Reset: rst_n=0 at t=0 -> busy=0, done=0, sum=0x0000, c_out=0, add_* all 0.
//  Add: a=0x1234,b=0x4321,c_in=0,op=0 -> done 5 edges after start, sum=0x5555, c_out=0.
//  Ripple: a=0xFFFF,b=0x0001,c_in=0 -> add_cin per nibble 0,1,1,1; sum=0x0000, c_out=1.
//  Sub: 0x5000-0x0001 -> sum=0x4FFF, c_out=1; 0x0000-0x0001 -> sum=0xFFFF, c_out=0.
//  Handshake: start held during RUN -> ignored; start in DONE cycle with 0x0F0F+0x00F1
//   -> busy next cycle, sum=0x1000, c_out=0.
//  Mid-op reset: rst_n=0 in 2nd RUN cycle -> all outputs 0, IDLE; new 0x0007+0x0009
//   -> sum=0x0010, c_out=0.

Source files
------------

// File: rtl/nibble_add_sequencer.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit adder.
// LSB nibble first, registered inter-nibble carry, start/done handshake.
module nibble_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_r;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == IDXW'(NIBBLES - 1));
    assign a_sh   = a_r >> {idx, 2'b00};
    assign b_sh   = b_r >> {idx, 2'b00};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Adder inputs are held at zero outside RUN so the shared adder stays quiet.
    assign add_a   = busy ? a_sh[3:0] : 4'h0;
    assign add_b   = busy ? (b_sh[3:0] ^ {4{op_r}}) : 4'h0;
    assign add_cin = busy ? carry : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            // Subtraction is a + ~b + ~c_in, so the borrow-in is inverted here.
            carry <= c_in ^ op;
            idx   <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IDXW'(i)) begin
                    sum[4*i +: 4] <= add_sum;
                end
            end
            carry <= add_cout;
            if (last) begin
                c_out <= add_cout;
                state <= DONE;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (WIDTH=16).
// The external 4-bit adder is modelled combinationally inside the bench.
module tb_nibble_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;

    int errors = 0;
    int checks = 0;

    logic [3:0] cins;
    logic       pre_done;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues a request in the current cycle and steps to the DONE cycle.
    // With hold set, start stays high with junk operands during RUN.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic top, input logic hold);
        start = 1'b1;
        a     = ta;
        b     = tb;
        c_in  = tc;
        op    = top;
        @(posedge clk);
        #1;
        if (hold) begin
            a = 16'hFFFF;
            b = 16'hFFFF;
            c_in = 1'b1;
            op = ~top;
        end else begin
            start = 1'b0;
        end
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cins[i] = add_cin;
            if (i == 3) begin
                pre_done = done;
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        cins  = '0;
        pre_done = 1'b0;
        #3;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'h0);
        chk("rst_c_out", {31'b0, c_out}, 32'd0);
        chk("rst_add_a", {28'b0, add_a}, 32'd0);
        chk("rst_add_b", {28'b0, add_b}, 32'd0);
        chk("rst_add_cin", {31'b0, add_cin}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        start = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        c_in = 1'b0;
        op = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("add_first_a", {28'b0, add_a}, 32'h4);
        chk("add_first_b", {28'b0, add_b}, 32'h1);
        chk("add_first_done", {31'b0, done}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("add_pre_done", {31'b0, done}, 32'd0);
        chk("add_pre_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("add_done", {31'b0, done}, 32'd1);
        chk("add_busy_low", {31'b0, busy}, 32'd0);
        chk("add_sum", {16'b0, sum}, 32'h5555);
        chk("add_c_out", {31'b0, c_out}, 32'd0);
        chk("add_quiet_a", {28'b0, add_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_sum_held", {16'b0, sum}, 32'h5555);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("ripple_cins", {28'b0, cins}, 32'hE);
        chk("ripple_pre_done", {31'b0, pre_done}, 32'd0);
        chk("ripple_done", {31'b0, done}, 32'd1);
        chk("ripple_sum", {16'b0, sum}, 32'h0000);
        chk("ripple_c_out", {31'b0, c_out}, 32'd1);

        run_op(16'h5000, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("sub1_sum", {16'b0, sum}, 32'h4FFF);
        chk("sub1_c_out", {31'b0, c_out}, 32'd1);

        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("sub2_sum", {16'b0, sum}, 32'hFFFF);
        chk("sub2_c_out", {31'b0, c_out}, 32'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        chk("hold_done", {31'b0, done}, 32'd1);
        chk("hold_sum", {16'b0, sum}, 32'h5555);
        chk("hold_c_out", {31'b0, c_out}, 32'd0);

        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_sum", {16'b0, sum}, 32'h1000);
        chk("b2b_c_out", {31'b0, c_out}, 32'd0);
        @(posedge clk);
        #1;

        start = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        op = 1'b0;
        c_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_done", {31'b0, done}, 32'd0);
        chk("mid_sum", {16'b0, sum}, 32'h0);
        chk("mid_c_out", {31'b0, c_out}, 32'd0);
        chk("mid_add_a", {28'b0, add_a}, 32'd0);
        chk("mid_add_cin", {31'b0, add_cin}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_idle", {31'b0, busy | done}, 32'd0);
        run_op(16'h0007, 16'h0009, 1'b0, 1'b0, 1'b0);
        chk("post_rst_done", {31'b0, done}, 32'd1);
        chk("post_rst_sum", {16'b0, sum}, 32'h0010);
        chk("post_rst_c_out", {31'b0, c_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
